trap_controller: RTL and testbench

//  Parametrised machine-mode trap unit, successor to the single-IRQ privilege block.

---
 rtl/trap_controller.sv | 138 +++++++++++++
 tb/tb_trap_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// ============================================================================
// Module   : trap_controller
// Purpose  : Machine-mode trap unit. It holds sticky, masked IRQ pending bits,
//            arbitrates them against synchronous exceptions, owns the trap
//            CSRs and drives a one-cycle PC redirect pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_controller #(
    parameter int          NUM_IRQ  = 4,
    parameter logic [31:0] VECTOR   = 32'h0000_0000,
    parameter bit          VECTORED = 1'b0
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic               I_ecall,
    input  logic               I_ebreak,
    input  logic               I_illegalinst,
    input  logic [NUM_IRQ-1:0] I_irq,
    input  logic               I_mret,
    input  logic [31:0]        I_pc,
    input  logic               I_msrwen,
    input  logic [11:0]        I_csraddr,
    input  logic [3:0]         I_rs1addr,
    input  logic [31:0]        I_rs1data,
    output logic [31:0]        O_csrdata,
    output logic               O_exception,
    output logic [31:0]        O_epcreturn,
    output logic [31:0]        O_evect
);

    logic [2:0]         mstatus;
    logic [4:0]         mcause;
    logic [31:0]        mepc;
    logic [31:0]        mevect;
    logic [NUM_IRQ-1:0] mie;
    logic [NUM_IRQ-1:0] mip;
    logic               exception;

    logic               csr_rw_page;
    logic               csr_ro_page;
    logic [3:0]         csr_sel;
    logic               csr_we;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mip_clr;
    logic [3:0]         irq_idx;
    logic [3:0]         sync_code;
    logic               sync_trap;
    logic               irq_trap;
    logic               accept;

    assign csr_rw_page = (I_csraddr[11:4] == 8'h7C);
    assign csr_ro_page = (I_csraddr[11:4] == 8'hFC);
    assign csr_sel     = I_csraddr[3:0];
    assign csr_we      = I_msrwen && (I_rs1addr != 4'd0) && csr_rw_page;

    assign pending   = mip & mie;
    assign sync_trap = I_ecall | I_ebreak | I_illegalinst;
    assign irq_trap  = mstatus[0] && (pending != '0);
    assign accept    = !exception && (sync_trap || irq_trap);
    assign mip_clr   = (csr_we && csr_sel == 4'h5) ? I_rs1data[NUM_IRQ-1:0] : '0;

    always_comb begin
        irq_idx = 4'd0;
        // Scan downward so the lowest pending index is the one that sticks
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) irq_idx = 4'(i);
        end
    end

    always_comb begin
        sync_code = 4'd11;
        if (I_illegalinst)  sync_code = 4'd2;
        else if (I_ebreak)  sync_code = 4'd3;
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            mstatus   <= 3'd0;
            mcause    <= 5'd0;
            mepc      <= 32'd0;
            mevect    <= VECTOR;
            mie       <= '0;
            mip       <= '0;
            exception <= 1'b0;
        end else begin
            exception <= accept;
            // A new request outranks a same-cycle W1C clear
            mip <= (mip & ~mip_clr) | I_irq;

            if (csr_we) begin
                case (csr_sel)
                    4'h0:    mstatus <= I_rs1data[2:0];
                    4'h1:    mcause  <= {I_rs1data[31], I_rs1data[3:0]};
                    4'h2:    mepc    <= I_rs1data;
                    4'h3:    mevect  <= I_rs1data;
                    4'h4:    mie     <= I_rs1data[NUM_IRQ-1:0];
                    default: ;
                endcase
            end

            // Later assignments override the CSR write for the trap/mret fields
            if (accept) begin
                mepc       <= I_pc;
                mstatus[1] <= mstatus[0];
                mstatus[0] <= 1'b0;
                mcause     <= sync_trap ? {1'b0, sync_code} : {1'b1, irq_idx};
            end else if (I_mret) begin
                mstatus[0] <= mstatus[1];
                mstatus[1] <= 1'b1;
            end
        end
    end

    always_comb begin
        O_csrdata = 32'hFFFF_FFFF;
        if (csr_rw_page || csr_ro_page) begin
            case (csr_sel)
                4'h0:    O_csrdata = {29'd0, mstatus};
                4'h1:    O_csrdata = {mcause[4], 27'd0, mcause[3:0]};
                4'h2:    O_csrdata = mepc;
                4'h3:    O_csrdata = mevect;
                4'h4:    O_csrdata = {{(32 - NUM_IRQ){1'b0}}, mie};
                4'h5:    O_csrdata = {{(32 - NUM_IRQ){1'b0}}, mip};
                default: O_csrdata = 32'hFFFF_FFFF;
            endcase
        end
    end

    assign O_exception = exception;
    assign O_epcreturn = mcause[4] ? mepc : mepc + 32'd4;
    assign O_evect     = (VECTORED && mcause[4]) ? mevect + {26'd0, mcause[3:0], 2'b00}
                                                 : mevect;

endmodule

`default_nettype wire

// File: tb/tb_trap_controller.sv
// ============================================================================
// Module   : tb_trap_controller
// Purpose  : Directed bench for trap_controller (vectored and flat instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trap_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ecall = 1'b0, ebreak = 1'b0, illegal = 1'b0, mret = 1'b0;
    logic [3:0]  irq = 4'd0;
    logic [31:0] pc = 32'd0;
    logic        msrwen = 1'b0;
    logic [11:0] csraddr = 12'h000;
    logic [3:0]  rs1addr = 4'd0;
    logic [31:0] rs1data = 32'd0;

    logic [31:0] csrdata, epcreturn, evect;
    logic        exception;
    logic [31:0] csrdata_f, epcreturn_f, evect_f;
    logic        exception_f;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    trap_controller #(.NUM_IRQ(4), .VECTOR(32'h0), .VECTORED(1'b1)) dut (
        .I_clk(clk), .I_rst(rst), .I_ecall(ecall), .I_ebreak(ebreak),
        .I_illegalinst(illegal), .I_irq(irq), .I_mret(mret), .I_pc(pc),
        .I_msrwen(msrwen), .I_csraddr(csraddr), .I_rs1addr(rs1addr),
        .I_rs1data(rs1data), .O_csrdata(csrdata), .O_exception(exception),
        .O_epcreturn(epcreturn), .O_evect(evect)
    );

    trap_controller #(.NUM_IRQ(4), .VECTOR(32'h0), .VECTORED(1'b0)) dut_flat (
        .I_clk(clk), .I_rst(rst), .I_ecall(ecall), .I_ebreak(ebreak),
        .I_illegalinst(illegal), .I_irq(irq), .I_mret(mret), .I_pc(pc),
        .I_msrwen(msrwen), .I_csraddr(csraddr), .I_rs1addr(rs1addr),
        .I_rs1data(rs1data), .O_csrdata(csrdata_f), .O_exception(exception_f),
        .O_epcreturn(epcreturn_f), .O_evect(evect_f)
    );

    typedef struct {
        string       name;
        logic        wen;
        logic [11:0] waddr;
        logic [3:0]  rs1;
        logic [31:0] wdata;
        logic [11:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_csr(input string name, input logic [11:0] addr, input logic [31:0] exp);
        csraddr = addr;
        #1;
        check(name, csrdata, exp);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        msrwen  = 1'b1;
        csraddr = addr;
        rs1addr = 4'd1;
        rs1data = data;
        tick();
        msrwen  = 1'b0;
        rs1addr = 4'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_exc(input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (exception) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        vecs[0]  = '{"mevect_rst", 1'b0, 12'h7C3, 4'd1, 32'h0,         12'h7C3, 32'h0};
        vecs[1]  = '{"mevect_wr",  1'b1, 12'h7C3, 4'd1, 32'h200,       12'hFC3, 32'h200};
        vecs[2]  = '{"ro_mirror",  1'b1, 12'hFC3, 4'd1, 32'h300,       12'h7C3, 32'h200};
        vecs[3]  = '{"rs1_zero",   1'b1, 12'h7C3, 4'd0, 32'h400,       12'h7C3, 32'h200};
        vecs[4]  = '{"mie_width",  1'b1, 12'h7C4, 4'd2, 32'hFFFF_FFF6, 12'h7C4, 32'h6};
        vecs[5]  = '{"mcause_int", 1'b1, 12'h7C1, 4'd3, 32'h8000_001B, 12'h7C1, 32'h8000_000B};
        vecs[6]  = '{"mcause_exc", 1'b1, 12'h7C1, 4'd1, 32'h0000_0002, 12'hFC1, 32'h2};
        vecs[7]  = '{"mepc_wr",    1'b1, 12'h7C2, 4'd1, 32'h1234,      12'h7C2, 32'h1234};
        vecs[8]  = '{"unmapped9",  1'b0, 12'h7C9, 4'd1, 32'h0,         12'h7C9, 32'hFFFF_FFFF};
        vecs[9]  = '{"unmapped6",  1'b1, 12'h7C6, 4'd1, 32'h55,        12'h7C6, 32'hFFFF_FFFF};
        vecs[10] = '{"other_page", 1'b0, 12'h800, 4'd1, 32'h0,         12'h800, 32'hFFFF_FFFF};
        vecs[11] = '{"mstatus_wr", 1'b1, 12'h7C0, 4'd1, 32'hFFFF_FFFE, 12'h7C0, 32'h6};

        do_reset();
        check("rst_exc", {31'd0, exception}, 32'd0);
        for (int a = 0; a < 6; a++) check_csr("rst_csr", 12'h7C0 + 12'(a), 32'd0);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wen) begin
                msrwen  = 1'b1;
                csraddr = vecs[i].waddr;
                rs1addr = vecs[i].rs1;
                rs1data = vecs[i].wdata;
                tick();
                msrwen  = 1'b0;
                rs1addr = 4'd0;
            end
            check_csr(vecs[i].name, vecs[i].raddr, vecs[i].exp);
        end
        // mcause = exception 2 with mepc 0x1234 -> return past the instruction
        check("epc_plus4", epcreturn, 32'h1238);

        // Masked IRQ, lowest enabled pending line taken
        do_reset();
        wr(12'h7C4, 32'h6);
        wr(12'h7C0, 32'h1);
        irq = 4'b0100;
        pc  = 32'h100;
        tick();
        irq = 4'd0;
        wait_exc("t1_pulse");
        check_csr("t1_mcause", 12'h7C1, 32'h8000_0002);
        check_csr("t1_mepc", 12'h7C2, 32'h100);
        check_csr("t1_mstatus", 12'h7C0, 32'h2);
        check("t1_evect_vec", evect, 32'h8);
        check("t1_evect_flat", evect_f, 32'h0);
        tick();
        check("t1_pulse_end", {31'd0, exception}, 32'd0);

        // Vectored target with two pending lines
        wr(12'h7C5, 32'h4);
        check_csr("t2_mip_clr", 12'h7C5, 32'h0);
        wr(12'h7C3, 32'h200);
        pc = 32'h300;
        wr(12'h7C0, 32'h1);
        irq = 4'b0110;
        tick();
        irq = 4'd0;
        wait_exc("t2_pulse");
        check_csr("t2_mcause", 12'h7C1, 32'h8000_0001);
        check("t2_evect_vec", evect, 32'h204);
        check("t2_evect_flat", evect_f, 32'h200);
        check("t2_epcret", epcreturn, 32'h300);
        tick();
        check("t2_pulse_end", {31'd0, exception}, 32'd0);

        // W1C against a live request
        irq = 4'b0100;
        wr(12'h7C5, 32'h4);
        check_csr("t5_set_wins", 12'h7C5, 32'h6);
        irq = 4'd0;
        wr(12'h7C5, 32'h4);
        check_csr("t5_clear", 12'h7C5, 32'h2);
        wr(12'hFC5, 32'h2);
        check_csr("t5_ro_mip", 12'h7C5, 32'h2);

        // Sync priority over enabled IRQ; sources ignored during the pulse
        wr(12'h7C0, 32'h1);
        illegal = 1'b1;
        ecall   = 1'b1;
        irq     = 4'b0010;
        pc      = 32'h40;
        tick();
        illegal = 1'b0;
        irq     = 4'd0;
        pc      = 32'h60;
        check("t3_pulse", {31'd0, exception}, 32'd1);
        check_csr("t3_mcause", 12'h7C1, 32'h2);
        check_csr("t3_mepc", 12'h7C2, 32'h40);
        check_csr("t3_mip", 12'h7C5, 32'h2);
        check("t3_epcret", epcreturn, 32'h44);
        check("t3_evect", evect, 32'h200);
        tick();
        ecall = 1'b0;
        check("t3_ignored", {31'd0, exception}, 32'd0);
        check_csr("t3_mepc_kept", 12'h7C2, 32'h40);

        // Trap beats mret and mstatus write in the same cycle
        wr(12'h7C5, 32'h2);
        wr(12'h7C0, 32'h1);
        ebreak  = 1'b1;
        mret    = 1'b1;
        msrwen  = 1'b1;
        csraddr = 12'h7C0;
        rs1addr = 4'd1;
        rs1data = 32'h0;
        pc      = 32'h80;
        tick();
        ebreak  = 1'b0;
        mret    = 1'b0;
        msrwen  = 1'b0;
        rs1addr = 4'd0;
        check("t4_pulse", {31'd0, exception}, 32'd1);
        check_csr("t4_mcause", 12'h7C1, 32'h3);
        check_csr("t4_mstatus", 12'h7C0, 32'h2);
        check("t4_epcret", epcreturn, 32'h84);
        tick();
        mret = 1'b1;
        tick();
        mret = 1'b0;
        check_csr("t4_mret", 12'h7C0, 32'h3);

        // Reset in the middle of a handler overrides everything
        wr(12'h7C1, 32'h8000_000B);
        check_csr("t6_mcause", 12'h7C1, 32'h8000_000B);
        check("t6_epcret", epcreturn, 32'h80);
        rst   = 1'b1;
        ecall = 1'b1;
        irq   = 4'b0001;
        tick();
        rst   = 1'b0;
        ecall = 1'b0;
        irq   = 4'd0;
        check("t6_exc", {31'd0, exception}, 32'd0);
        for (int a = 0; a < 6; a++) check_csr("t6_csr", 12'h7C0 + 12'(a), 32'd0);
        check_csr("t6_unmapped", 12'h7C9, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
